count_arbiter: RTL and testbench

Round-robin scheduler that shares a single up/down counter between NREQ requesters. Each requester asks for a count run of a given length and direction; the block grants one requester at a time, loads and steps the shared counter, and signals completion with a one-cycle pulse. It sits between the requester blocks and the counter datapath, which it owns exclusively.

---
 rtl/count_arbiter_pkg.sv | 35 +++
 rtl/count_core.sv | 35 +++
 rtl/count_arbiter.sv | 154 +++++++++++++++
 tb/tb_count_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/count_arbiter_pkg.sv
// Shared types and helpers for the round-robin count arbiter.
// Holds the FSM state encoding and the rotating-priority search.
package count_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    // First set request at or after ptr, wrapping at nreq; returns ptr when none is set.
    function automatic logic [IDX_W-1:0] rr_next(
        input logic [IDX_W-1:0]   ptr,
        input logic [MAX_REQ-1:0] req,
        input int                 nreq
    );
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] idx;
        logic             found;
        logic             hit;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx   = IDX_W'((int'(ptr) + i) % nreq);
            hit   = (i < nreq) && req[idx];
            pick  = (hit && !found) ? idx : pick;
            found = found | hit;
        end
        return pick;
    endfunction

endpackage

// File: rtl/count_core.sv
// Shared WIDTH-bit up/down counter with synchronous load and terminal compare.
// Owned exclusively by count_arbiter; load has priority over stepping.
module count_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             at_term
);

    logic [WIDTH-1:0] count_r;

    // Counter register: load, step by one, or hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (en) begin
            count_r <= up ? (count_r + WIDTH'(1)) : (count_r - WIDTH'(1));
        end else begin
            count_r <= count_r;
        end
    end

    assign count   = count_r;
    assign at_term = (count_r == term);

endmodule

// File: rtl/count_arbiter.sv
// Round-robin scheduler sharing one up/down counter among NREQ requesters.
// Grants one requester per run, steps the counter to its terminal and pulses done.
module count_arbiter
    import count_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  act,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len,
    input  logic [NREQ-1:0]       updown,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [WIDTH-1:0]      out,
    output logic [NREQ-1:0]       done
);

    localparam int               LEN_PAD_W = MAX_REQ * WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NREQ - 1);

    state_t             state_r, state_s;
    logic [IDX_W-1:0]   ptr_r, ptr_s;
    logic [IDX_W-1:0]   k_r, k_s;
    logic [WIDTH-1:0]   len_r, len_s;
    logic               up_r, up_s;
    logic [NREQ-1:0]    gnt_r, gnt_s;
    logic               busy_r, busy_s;
    logic [NREQ-1:0]    done_r, done_s;

    logic [MAX_REQ-1:0]   req_pad_s;
    logic [MAX_REQ-1:0]   updown_pad_s;
    logic [LEN_PAD_W-1:0] len_pad_s;
    logic [IDX_W-1:0]     pick_s;
    logic [WIDTH-1:0]     pick_len_s;
    logic [IDX_W-1:0]     next_ptr_s;
    logic                 owner_req_s;
    logic                 load_s;
    logic [WIDTH-1:0]     load_val_s;
    logic                 en_s;
    logic [WIDTH-1:0]     term_s;
    logic                 at_term_s;

    // Widen request-side vectors to the helper's fixed width so any NREQ indexes cleanly.
    assign req_pad_s    = MAX_REQ'(req);
    assign updown_pad_s = MAX_REQ'(updown);
    assign len_pad_s    = LEN_PAD_W'(len);

    assign pick_s      = rr_next(ptr_r, req_pad_s, NREQ);
    assign pick_len_s  = len_pad_s[int'(pick_s)*WIDTH +: WIDTH];
    assign next_ptr_s  = (k_r == LAST_IDX) ? {IDX_W{1'b0}} : (k_r + IDX_W'(1));
    assign owner_req_s = req_pad_s[k_r];
    assign term_s      = up_r ? len_r : {WIDTH{1'b0}};
    assign en_s        = (state_r == RUN) && owner_req_s && !at_term_s && act;

    count_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .load_val (load_val_s),
        .en       (en_s),
        .up       (up_r),
        .term     (term_s),
        .count    (out),
        .at_term  (at_term_s)
    );

    // Next-state and next-output logic; abort has priority over reaching terminal.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        k_s        = k_r;
        len_s      = len_r;
        up_s       = up_r;
        gnt_s      = gnt_r;
        busy_s     = busy_r;
        done_s     = {NREQ{1'b0}};
        load_s     = 1'b0;
        load_val_s = {WIDTH{1'b0}};
        case (state_r)
            IDLE: begin
                if (|req_pad_s) begin
                    k_s        = pick_s;
                    len_s      = pick_len_s;
                    up_s       = updown_pad_s[pick_s];
                    load_s     = 1'b1;
                    load_val_s = updown_pad_s[pick_s] ? {WIDTH{1'b0}} : pick_len_s;
                    gnt_s      = NREQ'(8'b0000_0001 << pick_s);
                    busy_s     = 1'b1;
                    state_s    = RUN;
                end else begin
                    gnt_s  = {NREQ{1'b0}};
                    busy_s = 1'b0;
                end
            end
            RUN: begin
                if (!owner_req_s) begin
                    gnt_s   = {NREQ{1'b0}};
                    busy_s  = 1'b0;
                    ptr_s   = next_ptr_s;
                    state_s = IDLE;
                end else if (at_term_s) begin
                    done_s  = gnt_r;
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                gnt_s   = {NREQ{1'b0}};
                busy_s  = 1'b0;
                ptr_s   = next_ptr_s;
                state_s = IDLE;
            end
            default: begin
                gnt_s   = {NREQ{1'b0}};
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // FSM and registered-output state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            ptr_r   <= {IDX_W{1'b0}};
            k_r     <= {IDX_W{1'b0}};
            len_r   <= {WIDTH{1'b0}};
            up_r    <= 1'b0;
            gnt_r   <= {NREQ{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= {NREQ{1'b0}};
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            k_r     <= k_s;
            len_r   <= len_s;
            up_r    <= up_s;
            gnt_r   <= gnt_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign gnt  = gnt_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_count_arbiter.sv
// Self-checking bench for count_arbiter: directed vector table, corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_count_arbiter;

    logic        clk;
    logic        reset;
    logic        act;
    logic [3:0]  req;
    logic [31:0] len;
    logic [3:0]  updown;
    logic [3:0]  gnt;
    logic        busy;
    logic [7:0]  out;
    logic [3:0]  done;

    int checks   = 0;
    int failures = 0;

    count_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .act    (act),
        .req    (req),
        .len    (len),
        .updown (updown),
        .gnt    (gnt),
        .busy   (busy),
        .out    (out),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] len;
        logic [3:0]  updown;
        logic        act;
        logic [3:0]  gnt;
        logic        busy;
        logic [7:0]  out;
        logic [3:0]  done;
    } vec_t;

    vec_t vq[$];

    // Reference model: owner index, steps remaining to terminal, finishing flag.
    int         m_owner;
    int         m_ptr;
    int         m_steps;
    int         m_len;
    bit         m_up;
    bit         m_fin;
    logic [7:0] m_out;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] eg, input logic eb,
                         input logic [7:0] eo, input logic [3:0] ed);
        checks++;
        if ({gnt, busy, out, done} !== {eg, eb, eo, ed}) begin
            failures++;
            $display("FAIL %s: got gnt=%b busy=%b out=%0d done=%b, expected gnt=%b busy=%b out=%0d done=%b",
                     name, gnt, busy, out, done, eg, eb, eo, ed);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic [31:0] l, input logic [3:0] u, input logic a,
                       input logic [3:0] eg, input logic eb, input logic [7:0] eo, input logic [3:0] ed);
        vec_t v;
        v.req = r; v.len = l; v.updown = u; v.act = a;
        v.gnt = eg; v.busy = eb; v.out = eo; v.done = ed;
        vq.push_back(v);
    endtask

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_steps = 0; m_len = 0;
        m_up = 1'b0; m_fin = 1'b0; m_out = 8'd0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        if (m_fin) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
            m_fin   = 1'b0;
        end else if (m_owner < 0) begin
            for (int i = 0; i < 4; i++) begin
                int c;
                c = (m_ptr + i) % 4;
                if (m_owner < 0 && req[c]) m_owner = c;
            end
            if (m_owner >= 0) begin
                m_len   = int'(len[m_owner*8 +: 8]);
                m_up    = updown[m_owner];
                m_steps = m_len;
                m_out   = m_up ? 8'd0 : 8'(m_len);
            end
        end else if (!req[m_owner]) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
        end else if (m_steps == 0) begin
            m_fin = 1'b1;
        end else if (act) begin
            m_steps = m_steps - 1;
            m_out   = m_up ? 8'(m_len - m_steps) : 8'(m_steps);
        end
    endtask

    initial begin
        logic [3:0] eg;
        logic [3:0] r;

        reset = 1'b0; act = 1'b0; req = 4'd0; len = 32'd0; updown = 4'd0;

        // Reset held: outputs stay clear whatever req and act do.
        for (int i = 0; i < 4; i++) begin
            req = 4'($urandom);
            act = 1'(i % 2);
            tick();
            check("reset_hold", 4'd0, 1'b0, 8'd0, 4'd0);
        end
        req = 4'd0; act = 1'b1;
        reset = 1'b1;
        tick();
        check("reset_release", 4'd0, 1'b0, 8'd0, 4'd0);

        // Up run len 5 on requester 1.
        add(4'b0010, 32'h0000_0500, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'd0, 4'b0000);
        for (int i = 1; i <= 5; i++)
            add(4'b0010, 32'h0000_0500, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'(i), 4'b0000);
        add(4'b0010, 32'h0000_0500, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'd5, 4'b0010);
        add(4'b0000, 32'h0000_0500, 4'b0010, 1'b1, 4'b0000, 1'b0, 8'd5, 4'b0000);
        // Down run len 3 on requester 2 with two paused cycles.
        add(4'b0100, 32'h0003_0000, 4'b0000, 1'b1, 4'b0100, 1'b1, 8'd3, 4'b0000);
        add(4'b0100, 32'h0000_0000, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'd2, 4'b0000);
        add(4'b0100, 32'h0000_0000, 4'b0100, 1'b0, 4'b0100, 1'b1, 8'd2, 4'b0000);
        add(4'b0100, 32'h0000_0000, 4'b0100, 1'b0, 4'b0100, 1'b1, 8'd2, 4'b0000);
        add(4'b0100, 32'h0000_0000, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'd1, 4'b0000);
        add(4'b0100, 32'h0000_0000, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'd0, 4'b0000);
        add(4'b0100, 32'h0000_0000, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'd0, 4'b0100);
        add(4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'd0, 4'b0000);
        // len 0 up on requester 3: one RUN cycle then DONE.
        add(4'b1000, 32'h0000_0000, 4'b1000, 1'b1, 4'b1000, 1'b1, 8'd0, 4'b0000);
        add(4'b1000, 32'h0000_0000, 4'b1000, 1'b1, 4'b1000, 1'b1, 8'd0, 4'b1000);
        add(4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'd0, 4'b0000);

        foreach (vq[i]) begin
            req = vq[i].req; len = vq[i].len; updown = vq[i].updown; act = vq[i].act;
            tick();
            check($sformatf("vec%0d", i), vq[i].gnt, vq[i].busy, vq[i].out, vq[i].done);
        end

        // Round robin: all requesting, len 1 each, order 0,1,2,3,0.
        req = 4'b1111; len = 32'h0101_0101; updown = 4'b1111; act = 1'b1;
        for (int r_i = 0; r_i < 5; r_i++) begin
            eg = 4'(1 << (r_i % 4));
            tick(); check("rr_grant", eg, 1'b1, 8'd0, 4'd0);
            tick(); check("rr_step", eg, 1'b1, 8'd1, 4'd0);
            tick(); check("rr_done", eg, 1'b1, 8'd1, eg);
            if (r_i == 4) req = 4'd0;
            tick(); check("rr_idle", 4'd0, 1'b0, 8'd1, 4'd0);
        end

        // Async reset in the middle of a run.
        req = 4'b0010; len = 32'h0000_0500; updown = 4'b0010; act = 1'b1;
        tick(); check("ar_grant", 4'b0010, 1'b1, 8'd0, 4'd0);
        tick(); tick(); check("ar_mid", 4'b0010, 1'b1, 8'd2, 4'd0);
        #2 reset = 1'b0;
        #1 check("ar_immediate", 4'd0, 1'b0, 8'd0, 4'd0);
        for (int i = 0; i < 2; i++) begin
            req = 4'($urandom); act = ~act;
            tick(); check("ar_held", 4'd0, 1'b0, 8'd0, 4'd0);
        end
        req = 4'd0; act = 1'b1; reset = 1'b1;
        tick(); check("ar_release", 4'd0, 1'b0, 8'd0, 4'd0);

        // Abort: requester 0 drops at out=2 of len 10; requester 2 must win next.
        req = 4'b0001; len = 32'h0001_000A; updown = 4'b0101;
        tick(); check("ab_grant", 4'b0001, 1'b1, 8'd0, 4'd0);
        req = 4'b0101;
        tick(); check("ab_step1", 4'b0001, 1'b1, 8'd1, 4'd0);
        tick(); check("ab_step2", 4'b0001, 1'b1, 8'd2, 4'd0);
        req = 4'b0100;
        tick(); check("ab_abort", 4'd0, 1'b0, 8'd2, 4'd0);
        req = 4'b0101;
        tick(); check("ab_next", 4'b0100, 1'b1, 8'd0, 4'd0);
        tick(); check("ab_next_step", 4'b0100, 1'b1, 8'd1, 4'd0);
        tick(); check("ab_next_done", 4'b0100, 1'b1, 8'd1, 4'b0100);
        req = 4'd0;
        tick(); check("ab_idle", 4'd0, 1'b0, 8'd1, 4'd0);

        // Randomized traffic against the reference model.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            r = req;
            for (int c = 0; c < 4; c++) begin
                if (m_owner == c) begin
                    if ($urandom_range(0, 39) == 0) r[c] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    r[c] = ~r[c];
                end
            end
            req    = r;
            len    = $urandom & 32'h0707_0707;
            updown = 4'($urandom);
            act    = ($urandom_range(0, 4) != 0);
            model_step();
            tick();
            eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
            check("random", eg, (m_owner >= 0), m_out, m_fin ? eg : 4'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
